// File: rtl/npu_axi_pkg.sv
// Shared types and constants for the NPU AXI4 read-port arbiter.
package npu_axi_pkg;

  // Arbiter sequencing: pick a client, issue its AR, stream its R beats.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // err_code bit positions: {id_mismatch, resp_error, last_mismatch}
  localparam int unsigned ERR_BIT_LAST = 0;
  localparam int unsigned ERR_BIT_RESP = 1;
  localparam int unsigned ERR_BIT_ID   = 2;

endpackage

// File: rtl/npu_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module npu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned IW  = $clog2(NUM_REQ);
  localparam int unsigned IW1 = IW + 1;
  localparam logic [IW:0] NR_W = IW1'(NUM_REQ);

  logic [IW:0] cand;
  logic        found;

  // Scan candidates in priority order starting at rr_ptr; the one-bit-wider
  // sum lets the wrap work for non-power-of-two client counts.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + IW1'(i);
      if (cand >= NR_W) begin
        cand = cand - NR_W;
      end
      if (!found && req[cand[IW-1:0]]) begin
        found                  = 1'b1;
        grant[cand[IW-1:0]]    = 1'b1;
        grant_idx              = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/npu_axi_rd_arbiter.sv
// Shares one AXI4 read master (AR/R) between NUM_REQ NPU DMA read clients,
// one burst at a time, with per-beat protocol checking.
module npu_axi_rd_arbiter
  import npu_axi_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                          m00_axi_aclk,
  input  logic                          m00_axi_areset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]          req_len,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_last,
  output logic [ID_WIDTH-1:0]           m00_axi_arid,
  output logic [ADDR_WIDTH-1:0]         m00_axi_araddr,
  output logic [7:0]                    m00_axi_arlen,
  output logic [2:0]                    m00_axi_arsize,
  output logic [1:0]                    m00_axi_arburst,
  output logic                          m00_axi_arvalid,
  input  logic                          m00_axi_arready,
  input  logic [ID_WIDTH-1:0]           m00_axi_rid,
  input  logic [DATA_WIDTH-1:0]         m00_axi_rdata,
  input  logic [1:0]                    m00_axi_rresp,
  input  logic                          m00_axi_rlast,
  input  logic                          m00_axi_rvalid,
  output logic                          m00_axi_rready,
  output logic                          busy,
  output logic                          err,
  output logic [2:0]                    err_code,
  input  logic                          err_clr
);

  localparam int unsigned IW  = $clog2(NUM_REQ);
  localparam int unsigned IW1 = IW + 1;
  localparam logic [IW:0] NR_W     = IW1'(NUM_REQ);
  localparam logic [2:0]  AXI_SIZE = 3'($clog2(DATA_WIDTH / 8));

  rd_state_e               state_q, state_d;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]           g_q, g_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [2:0]              err_code_q, err_code_d;

  logic [NUM_REQ-1:0]      win_grant;
  logic [IW-1:0]           win_idx;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic [7:0]              len_sel;
  logic [IW:0]             g_inc;
  logic [2:0]              err_new;
  logic                    in_idle, in_addr, in_data;
  logic                    accept, r_hs;

  npu_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (win_grant),
    .grant_idx (win_idx)
  );

  assign in_idle = (state_q == ST_IDLE);
  assign in_addr = (state_q == ST_ADDR);
  assign in_data = (state_q == ST_DATA);

  // Reset also masks the combinational accept so no grant leaks out while held.
  assign accept = in_idle && (|req_valid) && !m00_axi_areset;
  assign r_hs   = in_data && m00_axi_rvalid && rsp_ready[g_q];
  assign g_inc  = {1'b0, g_q} + IW1'(1);

  // Select the winning client's burst descriptor from the flat request buses.
  always_comb begin
    addr_sel = '0;
    len_sel  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) begin
        addr_sel = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        len_sel  = req_len[i*8 +: 8];
      end
    end
  end

  // Burst sequencing, beat counting, round-robin pointer and error flags.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    g_d      = g_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    err_new  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = addr_sel;
          len_d   = len_sel;
          g_d     = win_idx;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m00_axi_arready) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          cnt_d                 = cnt_q + 8'd1;
          err_new[ERR_BIT_RESP] = (m00_axi_rresp != AXI_RESP_OKAY);
          err_new[ERR_BIT_ID]   = (m00_axi_rid != ID_WIDTH'(g_q));
          err_new[ERR_BIT_LAST] = (m00_axi_rlast != (cnt_q == len_q));
          if (m00_axi_rlast) begin
            rr_ptr_d = (g_inc == NR_W) ? '0 : g_inc[IW-1:0];
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh error in the same cycle as err_clr survives the clear.
    err_code_d = (err_code_q & {3{~err_clr}}) | err_new;
    err_d      = (err_q & ~err_clr) | (|err_new);
  end

  // State registers with asynchronous abort on reset.
  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      g_q        <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      g_q        <= g_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // R beats steered to the granted client only.
  always_comb begin
    rsp_valid = '0;
    if (in_data) begin
      rsp_valid[g_q] = m00_axi_rvalid;
    end
  end

  assign req_ready       = accept ? win_grant : '0;
  assign rsp_data        = in_data ? m00_axi_rdata : '0;
  assign rsp_last        = in_data && m00_axi_rlast;
  assign m00_axi_rready  = in_data && rsp_ready[g_q];
  assign m00_axi_arvalid = in_addr;
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_arlen   = len_q;
  assign m00_axi_arid    = ID_WIDTH'(g_q);
  assign m00_axi_arsize  = AXI_SIZE;
  assign m00_axi_arburst = AXI_BURST_INCR;
  assign busy            = !in_idle;
  assign err             = err_q;
  assign err_code        = err_code_q;

endmodule

// File: tb/tb_npu_axi_rd_arbiter.sv
// Self-checking bench for npu_axi_rd_arbiter: the bench plays all clients and
// the AXI slave, and predicts grants, beats and error flags from a model.
module tb_npu_axi_rd_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IDW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*8-1:0]   req_len;
  logic [DW-1:0]     rsp_data;
  logic              rsp_last;
  logic [IDW-1:0]    arid;
  logic [AW-1:0]     araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid, arready;
  logic [IDW-1:0]    rid;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;
  logic              busy, err, err_clr;
  logic [2:0]        err_code;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ptr  = 0;
  logic [2:0] exp_err = '0;
  int cfg_stall_pct = 0;
  int cfg_ready_mode = 0;
  int cfg_ar_stall = 0;
  int cfg_bad_beat = -1;

  npu_axi_rd_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IDW)
  ) dut (
    .m00_axi_aclk    (clk),
    .m00_axi_areset  (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_len         (req_len),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_last        (rsp_last),
    .m00_axi_arid    (arid),
    .m00_axi_araddr  (araddr),
    .m00_axi_arlen   (arlen),
    .m00_axi_arsize  (arsize),
    .m00_axi_arburst (arburst),
    .m00_axi_arvalid (arvalid),
    .m00_axi_arready (arready),
    .m00_axi_rid     (rid),
    .m00_axi_rdata   (rdata),
    .m00_axi_rresp   (rresp),
    .m00_axi_rlast   (rlast),
    .m00_axi_rvalid  (rvalid),
    .m00_axi_rready  (rready),
    .busy            (busy),
    .err             (err),
    .err_code        (err_code),
    .err_clr         (err_clr)
  );

  always #5 clk = ~clk;

  // Slave memory contents: a distinct word per (start address, beat).
  function automatic logic [63:0] beat_data(input logic [31:0] a, input int b);
    return {a, 32'(b) ^ 32'h5A00_0000};
  endfunction

  // Round-robin reference: first valid client at or after the pointer.
  function automatic int model_winner(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[(exp_ptr + k) % NR]) return (exp_ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic set_client(input int c, input logic [31:0] a, input int len);
    req_addr[c*AW +: AW] = a;
    req_len[c*8 +: 8]    = 8'(len);
  endtask

  // Entered at negedge+1; waits at most max_wait extra cycles for a grant.
  task automatic grant_wait(input int cli, input int max_wait);
    logic [NR-1:0] exp_g;
    bit seen;
    exp_g = NR'(1) << cli;
    seen  = (req_ready !== '0);
    for (int c = 0; c < max_wait && !seen; c++) begin
      @(negedge clk); #1;
      seen = (req_ready !== '0);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL grant_timeout: req_ready=%b required %b", req_ready, exp_g);
    end else if (req_ready !== exp_g) begin
      n_fail++;
      $display("FAIL grant_onehot: req_ready=%b required %b", req_ready, exp_g);
    end
  endtask

  // Serves one burst after its accept cycle; ends at negedge+1 of the IDLE cycle.
  task automatic run_burst(input int cli, input logic [31:0] addr, input int len,
                           input int rlast_beat, input bit drop_req);
    logic [NR-1:0] oh;
    logic [44:0] exp_ar;
    int st, beat, cyc;
    bit done, rv, rr;
    oh     = NR'(1) << cli;
    exp_ar = {1'b1, addr, 8'(len), IDW'(cli)};
    @(negedge clk);
    if (drop_req) req_valid[cli] = 1'b0;
    arready = 1'b0;
    #1;
    n_checks++;
    if ({arvalid, araddr, arlen, arid} !== exp_ar) begin
      n_fail++;
      $display("FAIL ar_fields: got %h required %h", {arvalid, araddr, arlen, arid}, exp_ar);
    end
    n_checks++;
    if (req_ready !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_pulse: req_ready=%b busy=%b required 0000/1", req_ready, busy);
    end
    st = $urandom_range(0, cfg_ar_stall);
    for (int s = 0; s < st; s++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({arvalid, araddr, arlen, arid} !== exp_ar) begin
        n_fail++;
        $display("FAIL ar_stable: got %h required %h", {arvalid, araddr, arlen, arid}, exp_ar);
      end
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    beat = 0; cyc = 0; done = 0;
    while (!done && cyc < 2000) begin
      rv = ($urandom_range(0, 99) >= cfg_stall_pct);
      case (cfg_ready_mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 2 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      rsp_ready      = NR'($urandom_range(0, 15));
      rsp_ready[cli] = rr;
      rvalid = rv;
      rdata  = beat_data(addr, beat);
      rid    = (beat == cfg_bad_beat) ? IDW'(5) : IDW'(cli);
      rresp  = (beat == cfg_bad_beat) ? 2'b10 : 2'b00;
      rlast  = (beat == rlast_beat);
      #1;
      n_checks++;
      if (rready !== rr || rsp_valid !== (rv ? oh : '0)) begin
        n_fail++;
        $display("FAIL r_steer: rready=%b rsp_valid=%b required %b/%b", rready, rsp_valid, rr, rv ? oh : '0);
      end
      if (rv) begin
        n_checks++;
        if (rsp_data !== beat_data(addr, beat) || rsp_last !== rlast) begin
          n_fail++;
          $display("FAIL rsp_beat%0d: data=%h last=%b required %h/%b", beat, rsp_data, rsp_last,
                   beat_data(addr, beat), rlast);
        end
      end
      if (rv && rr) begin
        if (rresp != 2'b00) exp_err[1] = 1'b1;
        if (int'(rid) != cli) exp_err[2] = 1'b1;
        if (rlast != (beat == len)) exp_err[0] = 1'b1;
        if (rlast) done = 1;
        beat++;
      end
      cyc++;
      @(negedge clk);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    if (done) exp_ptr = (cli + 1) % NR;
    #1;
    n_checks++;
    if (!done || beat != rlast_beat + 1) begin
      n_fail++;
      $display("FAIL beat_count: beats=%0d done=%0d required %0d/1", beat, done, rlast_beat + 1);
    end
    n_checks++;
    if (busy !== 1'b0 || err !== (|exp_err) || err_code !== exp_err) begin
      n_fail++;
      $display("FAIL burst_end: busy=%b err=%b err_code=%b required 0/%b/%b", busy, err, err_code,
               |exp_err, exp_err);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_last, arid, araddr, arlen, arvalid,
         rready, busy, err, err_code} !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs %h required all zero", tag,
               {req_ready, rsp_valid, rsp_data, rsp_last, arid, araddr, arlen, arvalid,
                rready, busy, err, err_code});
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ptr = 0;
    exp_err = '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_len = '0; rsp_ready = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check_all_zero("reset_outputs");
    n_checks++;
    if (arsize !== 3'd3 || arburst !== 2'b01) begin
      n_fail++;
      $display("FAIL ar_consts: arsize=%0d arburst=%b required 3/01", arsize, arburst);
    end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_ptr = 0; exp_err = '0;
    #1;
  endtask

  task automatic test_single();
    cfg_stall_pct = 0; cfg_ready_mode = 0; cfg_ar_stall = 0; cfg_bad_beat = -1;
    @(negedge clk);
    set_client(0, 32'h1000, 3);
    req_valid = 4'b0001;
    #1;
    grant_wait(0, 0);
    run_burst(0, 32'h1000, 3, 3, 1);
  endtask

  task automatic test_rr_order();
    int w;
    apply_reset();
    cfg_stall_pct = 25; cfg_ready_mode = 2; cfg_ar_stall = 2; cfg_bad_beat = -1;
    set_client(0, 32'h0000_2000, 1);
    set_client(1, 32'h0001_2040, 4);
    set_client(2, 32'h0002_2080, 2);
    set_client(3, 32'h0003_20C0, 0);
    req_valid = 4'b1011;
    #1;
    for (int k = 0; k < 6; k++) begin
      w = model_winner(req_valid);
      grant_wait(w, (k == 0) ? 2 : 0);
      run_burst(w, req_addr[w*AW +: AW], int'(req_len[w*8 +: 8]), int'(req_len[w*8 +: 8]), 0);
    end
    req_valid = '0;
  endtask

  task automatic test_back_pressure();
    cfg_stall_pct = 20; cfg_ready_mode = 1; cfg_ar_stall = 1; cfg_bad_beat = -1;
    set_client(2, 32'h00C0_FFE0, 7);
    req_valid = 4'b0100;
    #1;
    grant_wait(2, 2);
    run_burst(2, 32'h00C0_FFE0, 7, 7, 1);
  endtask

  task automatic test_rlast_early();
    cfg_stall_pct = 0; cfg_ready_mode = 0; cfg_ar_stall = 0; cfg_bad_beat = -1;
    set_client(0, 32'h0000_3000, 3);
    req_valid = 4'b0001;
    #1;
    grant_wait(0, 2);
    run_burst(0, 32'h0000_3000, 3, 1, 1);
    n_checks++;
    if (err_code !== 3'b001) begin
      n_fail++;
      $display("FAIL early_rlast_code: err_code=%b required 001", err_code);
    end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = '0;
    #1;
    n_checks++;
    if (err !== 1'b0 || err_code !== 3'b000) begin
      n_fail++;
      $display("FAIL err_clr: err=%b err_code=%b required 0/000", err, err_code);
    end
  endtask

  task automatic test_resp_id_sticky();
    cfg_stall_pct = 0; cfg_ready_mode = 0; cfg_ar_stall = 0; cfg_bad_beat = 0;
    set_client(1, 32'h0000_4000, 2);
    req_valid = 4'b0010;
    #1;
    grant_wait(1, 2);
    run_burst(1, 32'h0000_4000, 2, 2, 1);
    n_checks++;
    if (err_code !== 3'b110 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_id_code: err=%b err_code=%b required 1/110", err, err_code);
    end
    cfg_bad_beat = -1;
    set_client(1, 32'h0000_5000, 1);
    req_valid = 4'b0010;
    #1;
    grant_wait(1, 2);
    run_burst(1, 32'h0000_5000, 1, 1, 1);
    n_checks++;
    if (err_code !== 3'b110 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_flags: err=%b err_code=%b required 1/110", err, err_code);
    end
  endtask

  task automatic test_reset_mid_burst();
    cfg_stall_pct = 0; cfg_ready_mode = 0; cfg_ar_stall = 0; cfg_bad_beat = -1;
    set_client(2, 32'h0000_6000, 5);
    set_client(0, 32'h0000_7000, 2);
    set_client(3, 32'h0000_8000, 1);
    req_valid = 4'b0100;
    #1;
    grant_wait(2, 2);
    @(negedge clk);
    req_valid = '0;
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid = 1'b1; rsp_ready = 4'b0100; rid = IDW'(2); rresp = 2'b00;
    rdata = beat_data(32'h0000_6000, 0); rlast = 1'b0;
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    n_checks++;
    if (busy !== 1'b1 || rsp_valid !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_burst_state: busy=%b rsp_valid=%b required 1/0100", busy, rsp_valid);
    end
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid_burst");
    @(negedge clk);
    rvalid = 1'b0;
    rst = 1'b0;
    exp_ptr = 0; exp_err = '0;
    #1;
    grant_wait(0, 0);
    run_burst(0, 32'h0000_7000, 2, 2, 1);
    grant_wait(3, 0);
    run_burst(3, 32'h0000_8000, 1, 1, 1);
  endtask

  task automatic test_random();
    int w, l;
    cfg_bad_beat = -1;
    for (int it = 0; it < 25; it++) begin
      cfg_stall_pct  = $urandom_range(0, 50);
      cfg_ready_mode = $urandom_range(0, 2);
      cfg_ar_stall   = $urandom_range(0, 3);
      for (int c = 0; c < NR; c++) begin
        set_client(c, {$urandom_range(0, 32'hFFFF), 3'b000, 13'(c * 64)},
                   $urandom_range(0, 15));
      end
      req_valid = NR'($urandom_range(1, 15));
      #1;
      w = model_winner(req_valid);
      l = int'(req_len[w*8 +: 8]);
      grant_wait(w, 0);
      run_burst(w, req_addr[w*AW +: AW], l, l, 1);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_back_pressure();
    test_rlast_early();
    test_resp_id_sticky();
    test_reset_mid_burst();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
